memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//   Shares one lower-layer memory port between two cache controllers (port 0: data cache,
//   port 1: instruction cache). Arbitrates, latches the winner's request, drives the memory
//   until memory_ack_i, then returns a one-cycle ack plus read line to the winner.
//   Sits between the cache controllers' memory_* outputs and the data memory model.
// PARAMETERS
//   ADDR_WIDTH     32   memory address width
//   LINE_WIDTH     256  cache line width (bits)
//   PRIORITY_MODE  0    0 = round-robin, 1 = fixed priority to port 0 with starvation guard
//   STARVE_LIMIT   4    fixed mode: port-1 losses in a row before port 1 is forced (1..15)
// PORTS
//   clock_i          in   1           clock, all state changes on rising edge
//   reset_n_i        in   1           synchronous active-low reset
//   p0_enable_i      in   1           port 0 request; held high until p0_ack_o seen
//   p0_write_i       in   1           port 0: 1 = write line, 0 = read line
//   p0_addr_i        in   ADDR_WIDTH  port 0 line address
//   p0_data_i        in   LINE_WIDTH  port 0 write line
//   p0_ack_o         out  1           port 0 completion pulse (one cycle)
//   p0_data_o        out  LINE_WIDTH  port 0 read line, valid only while p0_ack_o
//   p1_*             -    -           identical set for port 1
//   memory_enable_o  out  1           memory request, held until memory_ack_i
//   memory_write_o   out  1           memory write select
//   memory_addr_o    out  ADDR_WIDTH  memory address
//   memory_data_o    out  LINE_WIDTH  memory write line
//   memory_ack_i     in   1           memory completion
//   memory_data_i    in   LINE_WIDTH  memory read line, sampled when memory_ack_i
//   grant_o          out  2           one-hot current owner (bit0 = port 0), 0 in IDLE
// BEHAVIOUR
//   Reset (reset_n_i low at edge): state IDLE; all outputs 0; last_grant = 1; starve_cnt = 0.
//   All outputs registered or decoded from state/latched regs only (no input->output paths).
//   States: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: sample p0/p1_enable_i. None -> stay. Else pick winner, latch its write/addr/data,
//     set grant, go BUSY. Round-robin: both requesting -> port != last_grant; last_grant <= winner.
//     Fixed: port 0 wins unless starve_cnt == STARVE_LIMIT; starve_cnt +1 when port 1 loses a
//     contested arbitration, cleared whenever port 1 wins; saturates, never wraps.
//   BUSY: memory_enable_o = 1, memory_write/addr/data = latched values, stable every cycle.
//     memory_ack_i = 1 -> capture memory_data_i (read) or zero (write), go DONE.
//   DONE: memory_enable_o = 0; winner's pX_ack_o = 1 and pX_data_o = captured line; loser's ack 0
//     and data 0. Next state IDLE unconditionally (requester drops enable after ack, so the
//     following IDLE sample reflects its new state).
//   Latency: request sampled cycle 0 -> memory_enable_o high cycle 1; ack on cycle k ->
//     pX_ack_o cycle k+1; next arbitration cycle k+2. Minimum turnaround 3 cycles.
//   pX_data_o = 0 whenever pX_ack_o = 0.
//   Requester enable dropped during BUSY: ignored, transaction completes, ack still pulsed.
//   Inputs of granted port changing during BUSY: ignored (latched copy used).
//   memory_ack_i outside BUSY: ignored. Loser's request stays pending, no ack, served later.
//   Reset mid-BUSY: back to IDLE next edge, memory_enable_o 0, transaction abandoned, no ack.
// TESTING
//   1 Reset, p0 read 0x0000_0400, memory acks 2 cycles later with line 0xA5..A5 -> p0_ack_o
//     one pulse at cycle 4, p0_data_o = 0xA5..A5 that cycle, 0 otherwise; p1_ack_o never.
//   2 RR: p0 and p1 both request from reset -> p0 served first, then p1 (3-cycle gap
//     respected); repeat with both held -> grants alternate 0,1,0,1.
//   3 Fixed, STARVE_LIMIT=4, both always requesting -> grant order 0,0,0,0,1,0,0,0,0,1.
//   4 p1 write 0x0000_1000 data 0x1234.., p1 changes addr/data and drops enable mid-BUSY ->
//     memory sees original addr/data until ack; p1_ack_o pulses, p1_data_o = 0.
//   5 reset_n_i low during BUSY -> memory_enable_o 0 next cycle, no ack, grant_o = 0;
//     stray memory_ack_i in IDLE afterwards -> no ack output.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles both cache-controller ports and the shared memory port.
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  p0_enable_i;
  logic                  p0_write_i;
  logic [ADDR_WIDTH-1:0] p0_addr_i;
  logic [LINE_WIDTH-1:0] p0_data_i;
  logic                  p0_ack_o;
  logic [LINE_WIDTH-1:0] p0_data_o;
  logic                  p1_enable_i;
  logic                  p1_write_i;
  logic [ADDR_WIDTH-1:0] p1_addr_i;
  logic [LINE_WIDTH-1:0] p1_data_i;
  logic                  p1_ack_o;
  logic [LINE_WIDTH-1:0] p1_data_o;
  logic                  memory_enable_o;
  logic                  memory_write_o;
  logic [ADDR_WIDTH-1:0] memory_addr_o;
  logic [LINE_WIDTH-1:0] memory_data_o;
  logic                  memory_ack_i;
  logic [LINE_WIDTH-1:0] memory_data_i;
  logic [1:0]            grant_o;
  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  memory_ack_i, memory_data_i,
    output p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
    output memory_enable_o, memory_write_o, memory_addr_o, memory_data_o, grant_o
  );
  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output memory_ack_i, memory_data_i,
    input  p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
    input  memory_enable_o, memory_write_o, memory_addr_o, memory_data_o, grant_o
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between the data cache (port 0) and instruction cache (port 1).
module memory_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_WIDTH    = 256,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input logic clock_i,
  input logic reset_n_i,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  state_t                r_state;
  logic                  r_last_grant;
  logic [3:0]            r_starve_cnt;
  logic                  r_owner;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [1:0]            r_grant;
  logic                  r_mem_en;
  logic                  r_p0_ack;
  logic                  r_p1_ack;
  logic [LINE_WIDTH-1:0] r_p0_data;
  logic [LINE_WIDTH-1:0] r_p1_data;
  logic                  w_any;
  logic                  w_both;
  logic                  w_winner;
  always_comb begin
    w_any    = bus.p0_enable_i | bus.p1_enable_i;
    w_both   = bus.p0_enable_i & bus.p1_enable_i;
    w_winner = !w_both ? bus.p1_enable_i :
               (PRIORITY_MODE != 0) ? (r_starve_cnt == STARVE_MAX) : !r_last_grant;
  end
  // Winner's request is latched on arbitration so later input changes cannot disturb the memory bus.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_starve_cnt <= '0;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_grant      <= '0;
      r_mem_en     <= 1'b0;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p0_data    <= '0;
      r_p1_data    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_owner      <= w_winner;
          r_write      <= w_winner ? bus.p1_write_i : bus.p0_write_i;
          r_addr       <= w_winner ? bus.p1_addr_i : bus.p0_addr_i;
          r_wdata      <= w_winner ? bus.p1_data_i : bus.p0_data_i;
          r_grant      <= w_winner ? 2'b10 : 2'b01;
          r_mem_en     <= 1'b1;
          r_last_grant <= w_winner;
          if (PRIORITY_MODE != 0)
            r_starve_cnt <= w_winner ? '0 :
                            (w_both && r_starve_cnt != STARVE_MAX) ? r_starve_cnt + 4'd1 : r_starve_cnt;
          r_state      <= BUSY;
        end
        BUSY: if (bus.memory_ack_i) begin
          r_mem_en  <= 1'b0;
          r_p0_ack  <= !r_owner;
          r_p1_ack  <= r_owner;
          r_p0_data <= (!r_owner && !r_write) ? bus.memory_data_i : '0;
          r_p1_data <= (r_owner && !r_write) ? bus.memory_data_i : '0;
          r_state   <= DONE;
        end
        DONE: begin
          r_p0_ack  <= 1'b0;
          r_p1_ack  <= 1'b0;
          r_p0_data <= '0;
          r_p1_data <= '0;
          r_grant   <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.memory_enable_o = r_mem_en;
  assign bus.memory_write_o  = r_write;
  assign bus.memory_addr_o   = r_addr;
  assign bus.memory_data_o   = r_wdata;
  assign bus.grant_o         = r_grant;
  assign bus.p0_ack_o        = r_p0_ack;
  assign bus.p1_ack_o        = r_p1_ack;
  assign bus.p0_data_o       = r_p0_data;
  assign bus.p1_data_o       = r_p1_data;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: drives a round-robin and a fixed-priority arbiter against a transaction-level timing model.
module tb_memory_arbiter;
  localparam int LIM = 4;
  typedef struct packed {logic [31:0] addr; logic wr; logic [255:0] data;} req_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  memory_arbiter_if ifa ();
  memory_arbiter_if ifb ();
  memory_arbiter #(.PRIORITY_MODE(0)) dut_rr (.clock_i(clk), .reset_n_i(rst_n), .bus(ifa));
  memory_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(LIM)) dut_fx (.clock_i(clk), .reset_n_i(rst_n), .bus(ifb));
  logic en[4];
  logic wrq[4];
  logic [31:0] ad[4];
  logic [255:0] wd[4];
  logic mack[2];
  logic [255:0] mdat[2];
  assign ifa.p0_enable_i = en[0];
  assign ifa.p0_write_i = wrq[0];
  assign ifa.p0_addr_i = ad[0];
  assign ifa.p0_data_i = wd[0];
  assign ifa.p1_enable_i = en[1];
  assign ifa.p1_write_i = wrq[1];
  assign ifa.p1_addr_i = ad[1];
  assign ifa.p1_data_i = wd[1];
  assign ifa.memory_ack_i = mack[0];
  assign ifa.memory_data_i = mdat[0];
  assign ifb.p0_enable_i = en[2];
  assign ifb.p0_write_i = wrq[2];
  assign ifb.p0_addr_i = ad[2];
  assign ifb.p0_data_i = wd[2];
  assign ifb.p1_enable_i = en[3];
  assign ifb.p1_write_i = wrq[3];
  assign ifb.p1_addr_i = ad[3];
  assign ifb.p1_data_i = wd[3];
  assign ifb.memory_ack_i = mack[1];
  assign ifb.memory_data_i = mdat[1];
  // st: {grant[516:515], mem_en[514], ack0[513], ack1[512], data0, data1}; mb: {addr, write, data}
  logic [516:0] st[2];
  logic [288:0] mb[2];
  assign st[0] = {ifa.grant_o, ifa.memory_enable_o, ifa.p0_ack_o, ifa.p1_ack_o, ifa.p0_data_o, ifa.p1_data_o};
  assign st[1] = {ifb.grant_o, ifb.memory_enable_o, ifb.p0_ack_o, ifb.p1_ack_o, ifb.p0_data_o, ifb.p1_data_o};
  assign mb[0] = {ifa.memory_addr_o, ifa.memory_write_o, ifa.memory_data_o};
  assign mb[1] = {ifb.memory_addr_o, ifb.memory_write_o, ifb.memory_data_o};
  req_t rq[4][$];
  int glog[2][$];
  int total = 0, bad = 0, n = 0;
  int e[2], lt_len[2], rdy[2], stv[2], acks[4], ack_cyc[4];
  bit act[2], own[2], last[2];
  req_t lt[2];
  logic [255:0] ml[2];
  int lat_fix = -1;
  bit eager = 1, stray = 0, scram = 0, a5 = 0;

  // One clock of the whole bench: check both DUTs, move requesters and memories, predict arbitration.
  task automatic cycle(input bit rst_next);
    for (int d = 0; d < 2; d++) begin
      bit busy, done, b, w;
      logic [255:0] rl;
      logic [516:0] x;
      int k;
      busy = act[d] && n >= e[d] && n <= e[d] + lt_len[d];
      done = act[d] && n == e[d] + lt_len[d] + 1;
      rl = lt[d].wr ? '0 : ml[d];
      x = {(busy || done) ? (own[d] ? 2'b10 : 2'b01) : 2'b00, busy, done && !own[d], done && own[d],
           (done && !own[d]) ? rl : 256'h0, (done && own[d]) ? rl : 256'h0};
      total++;
      if (st[d] !== x) begin
        bad++;
        $display("FAIL status dut%0d cyc%0d got=%h exp=%h", d, n, st[d], x);
      end
      if (busy) begin
        total++;
        if (mb[d] !== lt[d]) begin
          bad++;
          $display("FAIL membus dut%0d cyc%0d got=%h exp=%h", d, n, mb[d], lt[d]);
        end
      end
      if (st[d][513] === 1'b1) begin acks[2*d]++; ack_cyc[2*d] = n; end
      if (st[d][512] === 1'b1) begin acks[2*d+1]++; ack_cyc[2*d+1] = n; end
      if (done) begin
        act[d] = 0;
        glog[d].push_back(int'(own[d]));
        rdy[d] = n + 1;
      end
      for (int p = 0; p < 2; p++) begin
        k = 2*d + p;
        if (done && int'(own[d]) == p) begin
          void'(rq[k].pop_front());
          en[k] = 0;
        end
        if (scram && busy && int'(own[d]) == p) begin
          ad[k] = $urandom;
          wd[k] = {8{$urandom}};
          if ($urandom_range(0, 1) == 1) en[k] = 0;
        end else if (!en[k] && rq[k].size() > 0 && !(act[d] && int'(own[d]) == p) &&
                     (eager || $urandom_range(0, 2) == 0)) begin
          en[k] = 1;
          ad[k] = rq[k][0].addr;
          wrq[k] = rq[k][0].wr;
          wd[k] = rq[k][0].data;
        end
      end
      mack[d] = (busy && n == e[d] + lt_len[d]) ? 1'b1 : (stray && !busy && $urandom_range(0, 1) == 1);
      mdat[d] = (busy && n == e[d] + lt_len[d]) ? ml[d] : {8{$urandom}};
      if (rst_next) begin
        act[d] = 0; last[d] = 1; stv[d] = 0; rdy[d] = 0;
      end else if (!act[d] && n >= rdy[d] && (en[2*d] || en[2*d+1])) begin
        b = en[2*d] && en[2*d+1];
        w = b ? (d == 0 ? !last[d] : (stv[d] == LIM)) : en[2*d+1];
        if (d == 1) stv[d] = w ? 0 : ((b && stv[d] < LIM) ? stv[d] + 1 : stv[d]);
        last[d] = w;
        own[d] = w;
        act[d] = 1;
        e[d] = n + 1;
        lt_len[d] = lat_fix >= 0 ? lat_fix : $urandom_range(0, 3);
        k = 2*d + int'(w);
        lt[d] = {ad[k], wrq[k], wd[k]};
        ml[d] = a5 ? {32{8'hA5}} : {8{$urandom}};
      end
    end
    rst_n = !rst_next;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run(input int max);
    int c = 0;
    while ((act[0] || act[1] || rq[0].size() > 0 || rq[1].size() > 0 || rq[2].size() > 0 ||
            rq[3].size() > 0) && c < max) begin
      cycle(0);
      c++;
    end
    total++;
    if (c >= max) begin
      bad++;
      $display("FAIL timeout cycles=%0d limit=%0d", c, max);
    end
    cycle(0);
    cycle(0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 4; k++) begin
      rq[k].delete(); en[k] = 0; acks[k] = 0; ack_cyc[k] = -1;
    end
    glog[0].delete();
    glog[1].delete();
    cycle(1);
    cycle(1);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total += 2;
      if (st[d] !== '0) begin bad++; $display("FAIL reset_status dut%0d got=%h exp=0", d, st[d]); end
      if (mb[d] !== '0) begin bad++; $display("FAIL reset_membus dut%0d got=%h exp=0", d, mb[d]); end
    end
    do_reset();
  endtask

  task automatic test_single_read();
    int n0;
    do_reset();
    lat_fix = 2; a5 = 1; eager = 1;
    rq[0].push_back({32'h0000_0400, 1'b0, 256'h0});
    n0 = n;
    run(50);
    total += 3;
    if (acks[0] !== 1) begin bad++; $display("FAIL read_p0_acks got=%0d exp=1", acks[0]); end
    if (acks[1] !== 0) begin bad++; $display("FAIL read_p1_acks got=%0d exp=0", acks[1]); end
    if (ack_cyc[0] !== n0 + 4) begin bad++; $display("FAIL read_ack_cycle got=%0d exp=%0d", ack_cyc[0] - n0, 4); end
    lat_fix = -1; a5 = 0;
  endtask

  task automatic test_round_robin();
    int exp_o[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    eager = 1;
    for (int i = 0; i < 3; i++) begin
      rq[0].push_back({$urandom, 1'b0, {8{$urandom}}});
      rq[1].push_back({$urandom, 1'($urandom_range(0, 1)), {8{$urandom}}});
    end
    run(200);
    total++;
    if (glog[0].size() !== 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", glog[0].size()); end
    for (int i = 0; i < 6 && i < glog[0].size(); i++) begin
      total++;
      if (glog[0][i] !== exp_o[i]) begin bad++; $display("FAIL rr_order idx%0d got=%0d exp=%0d", i, glog[0][i], exp_o[i]); end
    end
  endtask

  task automatic test_fixed_priority();
    int exp_o[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    eager = 1;
    for (int i = 0; i < 10; i++) rq[2].push_back({$urandom, 1'b0, {8{$urandom}}});
    for (int i = 0; i < 4; i++) rq[3].push_back({$urandom, 1'b0, {8{$urandom}}});
    run(300);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= glog[1].size() || glog[1][i] !== exp_o[i]) begin
        bad++;
        $display("FAIL fixed_order idx%0d got=%0d exp=%0d", i, (i < glog[1].size()) ? glog[1][i] : -1, exp_o[i]);
      end
    end
  endtask

  task automatic test_write_scramble();
    do_reset();
    eager = 1; lat_fix = 3; scram = 1;
    rq[1].push_back({32'h0000_1000, 1'b1, {8{32'h1234_5678}}});
    run(50);
    total += 2;
    if (acks[1] !== 1) begin bad++; $display("FAIL wr_p1_acks got=%0d exp=1", acks[1]); end
    if (acks[0] !== 0) begin bad++; $display("FAIL wr_p0_acks got=%0d exp=0", acks[0]); end
    scram = 0; lat_fix = -1;
  endtask

  task automatic test_reset_busy();
    do_reset();
    eager = 1; lat_fix = 6;
    rq[0].push_back({32'h0000_2000, 1'b0, 256'h0});
    repeat (3) cycle(0);
    cycle(1);
    rq[0].delete();
    en[0] = 0;
    total++;
    if (st[0][516:514] !== 3'b000) begin bad++; $display("FAIL rst_busy got=%b exp=000", st[0][516:514]); end
    stray = 1;
    repeat (10) cycle(0);
    stray = 0;
    total++;
    if (acks[0] !== 0) begin bad++; $display("FAIL rst_busy_ack got=%0d exp=0", acks[0]); end
    lat_fix = -1;
  endtask

  task automatic test_random();
    do_reset();
    eager = 0; stray = 1; scram = 1;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 15; i++) rq[k].push_back({$urandom, 1'($urandom_range(0, 1)), {8{$urandom}}});
    run(3000);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (acks[k] !== 15) begin bad++; $display("FAIL rand_acks port%0d got=%0d exp=15", k, acks[k]); end
    end
    eager = 1; stray = 0; scram = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin en[k] = 0; wrq[k] = 0; ad[k] = 0; wd[k] = 0; end
    for (int d = 0; d < 2; d++) begin
      mack[d] = 0; mdat[d] = 0; act[d] = 0; last[d] = 1; stv[d] = 0; rdy[d] = 0; e[d] = 0; lt_len[d] = 0;
      own[d] = 0; lt[d] = '0; ml[d] = '0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_scramble();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
